div_unit: RTL and testbench

//   Multi-cycle 32-bit signed integer divider for the datapath: the division counterpart of the Booth multiplier.

---
 rtl/div_unit_if.sv | 37 +++
 rtl/div_unit.sv | 142 ++++++++++++++
 tb/tb_div_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Request/result bundle for the multi-cycle divider.
// When DIV_UNSIGNED_EN is defined the bundle carries the div_unsigned select.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             DivControl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
`ifdef DIV_UNSIGNED_EN
    logic             div_unsigned;
`endif
    logic [WIDTH-1:0] resultHi;
    logic [WIDTH-1:0] resultLo;
    logic             busy;
    logic             done;
    logic             div_zero;

    // Handshake: DivControl is a one-cycle start request that is honoured only
    // when busy is low; A/B (and div_unsigned) are captured on that edge only.
    // done pulses for one cycle when resultHi/resultLo hold the new results;
    // div_zero pulses together with done when the divisor was zero.
    modport master (
        output DivControl, A, B,
`ifdef DIV_UNSIGNED_EN
        output div_unsigned,
`endif
        input  resultHi, resultLo, busy, done, div_zero
    );

    modport slave (
        input  DivControl, A, B,
`ifdef DIV_UNSIGNED_EN
        input  div_unsigned,
`endif
        output resultHi, resultLo, busy, done, div_zero
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring signed divider: quotient on resultLo, remainder on resultHi.
// Optional unsigned mode (DIVU) is enabled by defining DIV_UNSIGNED_EN.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    div_unit_if.slave  bus,
    output logic [1:0] dbg_state
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] bmag_q;
    logic             sign_q_q;
    logic             sign_r_q;
    logic [WIDTH-1:0] res_hi_q;
    logic [WIDTH-1:0] res_lo_q;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic             is_unsigned;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic             b_zero;
    logic [WIDTH:0]   shifted;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

`ifdef DIV_UNSIGNED_EN
    assign is_unsigned = bus.div_unsigned;
`else
    assign is_unsigned = 1'b0;
`endif

    // Magnitudes are unsigned WIDTH bits, so |most-negative| is representable.
    assign a_neg  = ~is_unsigned & bus.A[WIDTH-1];
    assign b_neg  = ~is_unsigned & bus.B[WIDTH-1];
    assign a_abs  = a_neg ? (~bus.A + 1'b1) : bus.A;
    assign b_abs  = b_neg ? (~bus.B + 1'b1) : bus.B;
    assign b_zero = (bus.B == '0);

    // One restoring step. When the shifted-out bit is set the partial
    // remainder already exceeds any WIDTH-bit divisor, and the true difference
    // is below 2^WIDTH, so the low WIDTH bits of the subtraction are exact.
    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign trial_ok = shifted[WIDTH] | (shifted[WIDTH-1:0] >= bmag_q);
    assign rem_step = trial_ok ? (shifted[WIDTH-1:0] - bmag_q) : shifted[WIDTH-1:0];
    assign quo_step = {quo_q[WIDTH-2:0], trial_ok};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.DivControl) begin
                    if (b_zero) begin
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (count_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            bmag_q   <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.DivControl && !b_zero) begin
                        quo_q    <= a_abs;
                        bmag_q   <= b_abs;
                        rem_q    <= '0;
                        sign_q_q <= a_neg ^ b_neg;
                        sign_r_q <= a_neg;
                        count_q  <= CW'(WIDTH);
                    end
                end
                S_RUN: begin
                    rem_q   <= rem_step;
                    quo_q   <= quo_step;
                    count_q <= count_q - CW'(1);
                end
                S_FIX: begin
                    // Most-negative / -1 wraps back to most-negative here.
                    res_lo_q <= sign_q_q ? (~quo_q + 1'b1) : quo_q;
                    res_hi_q <= sign_r_q ? (~rem_q + 1'b1) : rem_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.resultHi = res_hi_q;
    assign bus.resultLo = res_lo_q;
    assign bus.busy     = (state_q == S_RUN) || (state_q == S_FIX);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: random and directed divisions against a 64-bit arithmetic model.
// Define DIV_UNSIGNED_EN to also exercise the unsigned (DIVU) select.
module tb_div_unit;
    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    div_unit_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard entries: {div_zero, hi, lo} plus the cycle done must be seen.
    logic [2*W:0] exp_q[$];
    int           cyc_q[$];

    // Issue-side model: results of the last accepted op and next accepting edge.
    logic [W-1:0] pred_lo = '0;
    logic [W-1:0] pred_hi = '0;
    int           idle_at = 0;
    int           run_start = -100;
    // Monitor-side view of what resultHi/resultLo must currently hold.
    logic [W-1:0] mon_lo = '0;
    logic [W-1:0] mon_hi = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit uns);
        longint sa, sb, q, r;
        if (b == '0) return {1'b1, pred_hi, pred_lo};
        if (uns) begin
            sa = longint'(a);
            sb = longint'(b);
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[W-1:0], q[W-1:0]};
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit uns);
        int           e;
        bit           m_uns;
        logic [2*W:0] r;
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.DivControl = 1'b1;
`ifdef DIV_UNSIGNED_EN
        bus.div_unsigned = uns;
        m_uns = uns;
`else
        m_uns = 1'b0;
`endif
        e = cyc + 1;
        if (e >= idle_at) begin
            r = ref_div(a, b, m_uns);
            exp_q.push_back(r);
            if (b == '0) begin
                cyc_q.push_back(e);
                idle_at = e + 1;
            end else begin
                cyc_q.push_back(e + LAT);
                idle_at   = e + LAT + 1;
                run_start = e;
                pred_lo   = r[W-1:0];
                pred_hi   = r[2*W-1:W];
            end
        end
        @(negedge clk);
        bus.DivControl = 1'b0;
        bus.A = $urandom;
        bus.B = $urandom;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 3 * LAT && exp_q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        cyc_q.delete();
        pred_lo = '0;
        pred_hi = '0;
        mon_lo = '0;
        mon_hi = '0;
        idle_at = 0;
        run_start = -100;
        repeat (2) @(negedge clk);
        check("reset_lo", bus.resultLo, 0);
        check("reset_hi", bus.resultHi, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_dz", bus.div_zero, 0);
        check("reset_state_idle", dbg_state, 0);
        reset = 1'b0;
    endtask

    // Monitor: one look per cycle, well clear of the rising edge.
    initial begin
        logic [2*W:0] e;
        int           c;
        bit           exp_busy;
        forever begin
            @(negedge clk);
            #1;
            if (reset) continue;
            exp_busy = (cyc >= run_start) && (cyc <= run_start + W);
            check("busy", bus.busy, exp_busy);
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    check("done_cycle", cyc, c);
                    check("div_zero", bus.div_zero, e[2*W]);
                    mon_lo = e[W-1:0];
                    mon_hi = e[2*W-1:W];
                end
            end else begin
                check("div_zero_quiet", bus.div_zero, 0);
                if (cyc_q.size() != 0 && cyc_q[0] < cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL missed_done: got no done expected done at cycle %0d (now %0d)", cyc_q[0], cyc);
                    void'(exp_q.pop_front());
                    void'(cyc_q.pop_front());
                end
            end
            check("resultLo", bus.resultLo, mon_lo);
            check("resultHi", bus.resultHi, mon_hi);
        end
    end

    initial begin
        logic [W-1:0] a, b;
        bus.DivControl = 1'b0;
        bus.A = '0;
        bus.B = '0;
`ifdef DIV_UNSIGNED_EN
        bus.div_unsigned = 1'b0;
`endif
        reset = 1'b1;
        do_reset();

        start_op(32'd7, 32'd2, 1'b0);
        wait_drain();
        start_op(32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_drain();
        start_op(32'd7, 32'hFFFF_FFFE, 1'b0);
        wait_drain();
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_drain();

        // Divide by zero keeps the preloaded 3 / 1.
        start_op(32'd7, 32'd2, 1'b0);
        wait_drain();
        start_op(32'd5, 32'd0, 1'b0);
        wait_drain();

        // Reset mid-operation, then a clean rerun.
        start_op(32'd100, 32'd7, 1'b0);
        repeat (10) @(negedge clk);
        do_reset();
        start_op(32'd100, 32'd7, 1'b0);
        wait_drain();

        // Start while busy is ignored; a start in the done cycle is accepted.
        start_op(32'd9, 32'd3, 1'b0);
        repeat (5) @(negedge clk);
        start_op(32'd1, 32'd1, 1'b0);
        for (int k = 0; k < 3 * LAT && cyc < idle_at - 2; k++) @(negedge clk);
        start_op(32'd12, 32'hFFFF_FFFC, 1'b0);
        wait_drain();

`ifdef DIV_UNSIGNED_EN
        start_op(32'hFFFF_FFFF, 32'd2, 1'b1);
        wait_drain();
        start_op(32'hFFFF_FFFF, 32'd2, 1'b0);
        wait_drain();
`endif

        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            case ($urandom_range(0, 5))
                0: begin a = $urandom; b = '0; end
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = W'($urandom_range(0, 200)) - 32'd100; b = W'($urandom_range(0, 20)) - 32'd10; end
                3: begin a = $urandom; b = W'($urandom_range(1, 15)); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            start_op(a, b, 1'($urandom_range(0, 1)));
        end

        for (int k = 0; k < 4 * LAT && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
